// File: rtl/register_bank_pkg.sv
// rtl/register_bank_pkg.sv - shared pipeline constants for register file, decode and hazard logic
package register_bank_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef logic [DATA_W-1:0] reg_word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/register_bank_if.sv
// rtl/register_bank_if.sv - write-back write port and decode read ports of the register file
interface register_bank_if;
    import register_bank_pkg::*;

    logic      RegWrite;
    reg_addr_t wr_addr;
    reg_word_t wr_data;
    reg_addr_t rd_addr_a;
    reg_addr_t rd_addr_b;
    reg_word_t rd_data_a;
    reg_word_t rd_data_b;

    modport master (
        output RegWrite, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b
    );

    modport slave (
        input  RegWrite, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b
    );
endinterface

// File: rtl/register_bank_read_port.sv
// rtl/register_bank_read_port.sv - one asynchronous read port: index mux, r0 force, optional bypass
module regbank_read_port
    import register_bank_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b0
) (
    input  logic      reset,
    input  reg_word_t regs [NUM_REGS],
    input  reg_addr_t rd_addr,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  reg_word_t wr_data,
    output reg_word_t rd_data
);
    always_comb begin
        rd_data = regs[rd_addr];
        if (BYPASS_EN && wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
        // r0 and the reset window always read zero, even when the bypass matches
        if (reset || (rd_addr == REG_ZERO)) begin
            rd_data = '0;
        end
    end
endmodule

// File: rtl/register_bank.sv
// rtl/register_bank.sv - 32x32 register file, one write / two read ports; REGBANK_BYPASS_EN enables write-to-read bypass
module register_bank
    import register_bank_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    register_bank_if.slave  bus
);
`ifdef REGBANK_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    reg_word_t regs_q [NUM_REGS];
    reg_word_t regs_d [NUM_REGS];
    logic      wr_en;

    assign wr_en = bus.RegWrite && (bus.wr_addr != REG_ZERO);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regbank_read_port #(.BYPASS_EN(BYPASS_EN)) u_port_a (
        .reset   (reset),
        .regs    (regs_q),
        .rd_addr (bus.rd_addr_a),
        .wr_en   (wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_data (bus.rd_data_a)
    );

    regbank_read_port #(.BYPASS_EN(BYPASS_EN)) u_port_b (
        .reset   (reset),
        .regs    (regs_q),
        .rd_addr (bus.rd_addr_b),
        .wr_en   (wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_data (bus.rd_data_b)
    );
endmodule
